// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin arbiter sharing one I2C register-access master
module i2c_req_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GW             = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_start,
    input  logic [NUM_REQ-1:0]      req_is_read,
    input  logic [NUM_REQ*7-1:0]    req_dev_addr,
    input  logic [NUM_REQ*16-1:0]   req_reg_addr,
    input  logic [NUM_REQ*8-1:0]    req_wdata,
    input  logic [NUM_REQ*10-1:0]   req_nb_bytes,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      req_error,
    output logic [15:0]             req_rdata,
    output logic                    m_start,
    output logic                    m_is_read,
    output logic [6:0]              m_dev_addr,
    output logic [15:0]             m_reg_addr,
    output logic [7:0]              m_wdata,
    output logic [9:0]              m_nb_bytes,
    input  logic                    m_ready,
    input  logic                    m_error,
    input  logic [15:0]             m_rdata,
    output logic [GW-1:0]           grant_id,
    output logic                    busy
);

    localparam int WW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] LAST_IDX  = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t                state_q;
    logic [GW-1:0]         ptr_q;
    logic [WW-1:0]         wdog_q;
    logic [NUM_REQ-1:0]    req_ready_q;
    logic [NUM_REQ-1:0]    req_error_q;
    logic [15:0]           req_rdata_q;
    logic                  m_start_q;
    logic                  m_is_read_q;
    logic [6:0]            m_dev_addr_q;
    logic [15:0]           m_reg_addr_q;
    logic [7:0]            m_wdata_q;
    logic [9:0]            m_nb_bytes_q;
    logic [GW-1:0]         grant_id_q;
    logic                  busy_q;

    logic [GW-1:0]         sel_d;
    logic                  any_d;
    logic [GW-1:0]         cand;
    logic [GW-1:0]         ptr_d;

    // Scan from the highest offset down so the closest set bit at or after ptr wins.
    always_comb begin
        sel_d = '0;
        any_d = 1'b0;
        cand  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = GW'((int'(ptr_q) + i) % NUM_REQ);
            if (req_start[cand]) begin
                sel_d = cand;
                any_d = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = (sel_d == LAST_IDX) ? '0 : sel_d + GW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            wdog_q       <= '0;
            req_ready_q  <= '0;
            req_error_q  <= '0;
            req_rdata_q  <= '0;
            m_start_q    <= 1'b0;
            m_is_read_q  <= 1'b0;
            m_dev_addr_q <= '0;
            m_reg_addr_q <= '0;
            m_wdata_q    <= '0;
            m_nb_bytes_q <= '0;
            grant_id_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (any_d) begin
                        m_is_read_q  <= req_is_read[sel_d];
                        m_dev_addr_q <= req_dev_addr[sel_d*7 +: 7];
                        m_reg_addr_q <= req_reg_addr[sel_d*16 +: 16];
                        m_wdata_q    <= req_wdata[sel_d*8 +: 8];
                        m_nb_bytes_q <= req_nb_bytes[sel_d*10 +: 10];
                        m_start_q    <= 1'b1;
                        grant_id_q   <= sel_d;
                        ptr_q        <= ptr_d;
                        wdog_q       <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    wdog_q <= wdog_q + WW'(1);
                    // A completion on the timeout edge still counts as a normal completion.
                    if (m_ready) begin
                        m_start_q               <= 1'b0;
                        req_ready_q[grant_id_q] <= 1'b1;
                        req_error_q[grant_id_q] <= m_error;
                        req_rdata_q             <= m_rdata;
                        state_q                 <= S_RELEASE;
                    end else if (wdog_q == WDOG_LAST) begin
                        m_start_q               <= 1'b0;
                        req_ready_q[grant_id_q] <= 1'b1;
                        req_error_q[grant_id_q] <= 1'b1;
                        state_q                 <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    req_ready_q <= '0;
                    req_error_q <= '0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign req_error  = req_error_q;
    assign req_rdata  = req_rdata_q;
    assign m_start    = m_start_q;
    assign m_is_read  = m_is_read_q;
    assign m_dev_addr = m_dev_addr_q;
    assign m_reg_addr = m_reg_addr_q;
    assign m_wdata    = m_wdata_q;
    assign m_nb_bytes = m_nb_bytes_q;
    assign grant_id   = grant_id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// tb/tb_i2c_req_arbiter.sv - directed self-checking bench for i2c_req_arbiter
module tb_i2c_req_arbiter;

    localparam int N  = 4;
    localparam int T  = 16;
    localparam int GW = $clog2(N);

    logic              clk;
    logic              reset;
    logic [N-1:0]      req_start;
    logic [N-1:0]      req_is_read;
    logic [N*7-1:0]    req_dev_addr;
    logic [N*16-1:0]   req_reg_addr;
    logic [N*8-1:0]    req_wdata;
    logic [N*10-1:0]   req_nb_bytes;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_error;
    logic [15:0]       req_rdata;
    logic              m_start;
    logic              m_is_read;
    logic [6:0]        m_dev_addr;
    logic [15:0]       m_reg_addr;
    logic [7:0]        m_wdata;
    logic [9:0]        m_nb_bytes;
    logic              m_ready;
    logic              m_error;
    logic [15:0]       m_rdata;
    logic [GW-1:0]     grant_id;
    logic              busy;

    int n_assert = 0;
    int n_fail   = 0;
    int hi_cnt;

    i2c_req_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset),
        .req_start(req_start), .req_is_read(req_is_read),
        .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr),
        .req_wdata(req_wdata), .req_nb_bytes(req_nb_bytes),
        .req_ready(req_ready), .req_error(req_error), .req_rdata(req_rdata),
        .m_start(m_start), .m_is_read(m_is_read), .m_dev_addr(m_dev_addr),
        .m_reg_addr(m_reg_addr), .m_wdata(m_wdata), .m_nb_bytes(m_nb_bytes),
        .m_ready(m_ready), .m_error(m_error), .m_rdata(m_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_start = '0; req_is_read = '0;
        m_ready = 1'b0; m_error = 1'b0; m_rdata = '0;
        for (int i = 0; i < N; i++) begin
            req_dev_addr[7*i +: 7]   = 7'(8'h10 + i);
            req_reg_addr[16*i +: 16] = 16'(16'h0100 * i);
            req_wdata[8*i +: 8]      = 8'(8'hA0 + i);
            req_nb_bytes[10*i +: 10] = 10'(1 + i);
        end
        req_reg_addr[32 +: 16] = 16'h7FFF;
        req_wdata[16 +: 8]     = 8'h00;
        req_reg_addr[0 +: 16]  = 16'h0006;
        req_is_read[0]         = 1'b1;
        tick; tick;
        chk("rst_m_start", m_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_error", req_error, 0);
        chk("rst_rdata", req_rdata, 0);
        chk("rst_reg_addr", m_reg_addr, 0);
        reset = 1'b0;

        // master completion while idle is ignored
        m_ready = 1'b1; m_error = 1'b1; m_rdata = 16'hDEAD;
        tick;
        chk("idle_ready_ignored", req_ready, 0);
        chk("idle_rdata_ignored", req_rdata, 0);
        m_ready = 1'b0; m_error = 1'b0;

        // single write from requester 2
        req_start = 4'b0100;
        tick;
        chk("wr_m_start", m_start, 1);
        chk("wr_reg_addr", m_reg_addr, 16'h7FFF);
        chk("wr_dev_addr", m_dev_addr, 7'h12);
        chk("wr_wdata", m_wdata, 8'h00);
        chk("wr_nb", m_nb_bytes, 10'd3);
        chk("wr_is_read", m_is_read, 0);
        chk("wr_grant", grant_id, 2);
        chk("wr_busy", busy, 1);
        req_reg_addr[32 +: 16] = 16'h1111;
        tick; tick;
        chk("wr_frozen", m_reg_addr, 16'h7FFF);
        chk("wr_hold_start", m_start, 1);
        m_ready = 1'b1;
        tick;
        chk("wr_ready", req_ready, 4'b0100);
        chk("wr_error", req_error, 0);
        chk("wr_start_low", m_start, 0);
        chk("wr_busy_release", busy, 1);
        m_ready = 1'b0; req_start = '0;
        tick;
        chk("wr_ready_clr", req_ready, 0);
        chk("wr_busy_idle", busy, 0);

        // read from requester 0 (ptr is 3, wraps to 0)
        req_start = 4'b0001;
        tick;
        chk("rd_grant", grant_id, 0);
        chk("rd_is_read", m_is_read, 1);
        chk("rd_reg_addr", m_reg_addr, 16'h0006);
        m_ready = 1'b1; m_rdata = 16'h1234;
        tick;
        chk("rd_ready", req_ready, 4'b0001);
        chk("rd_rdata", req_rdata, 16'h1234);
        m_ready = 1'b0; m_rdata = 16'hBEEF; req_start = '0;
        tick;
        chk("rd_rdata_held", req_rdata, 16'h1234);
        chk("rd_ready_clr", req_ready, 0);

        // NACK on requester 3 (ptr is 1, search 1,2,3)
        req_start = 4'b1000;
        tick;
        chk("nack_grant", grant_id, 3);
        m_ready = 1'b1; m_error = 1'b1;
        tick;
        chk("nack_ready", req_ready, 4'b1000);
        chk("nack_error", req_error, 4'b1000);
        m_ready = 1'b0; m_error = 1'b0; req_start = '0;
        tick;
        chk("nack_error_clr", req_error, 0);

        // contention: all four held, ptr is 0 -> order 0,1,2,3,0
        req_start = 4'b1111; m_rdata = 16'h5A5A;
        for (int j = 0; j < 5; j++) begin
            tick;
            chk("cont_grant", grant_id, j % N);
            chk("cont_dev", m_dev_addr, 7'(8'h10 + (j % N)));
            chk("cont_start", m_start, 1);
            m_ready = 1'b1;
            tick;
            chk("cont_ready", req_ready, 4'b0001 << (j % N));
            chk("cont_error", req_error, 0);
            m_ready = 1'b0;
            tick;
            chk("cont_idle", busy, 0);
        end
        req_start = '0;
        tick;

        // watchdog timeout on requester 1 (ptr is 1)
        m_rdata = 16'h1111;
        req_start = 4'b0010;
        tick;
        chk("to_grant", grant_id, 1);
        hi_cnt = m_start ? 1 : 0;
        for (int c = 1; c < T; c++) begin
            tick;
            if (m_start) hi_cnt++;
        end
        chk("to_high_cycles", hi_cnt, T);
        tick;
        chk("to_start_low", m_start, 0);
        chk("to_ready", req_ready, 4'b0010);
        chk("to_error", req_error, 4'b0010);
        chk("to_rdata_kept", req_rdata, 16'h5A5A);
        req_start = '0;
        tick;
        chk("to_busy_clr", busy, 0);
        chk("to_ready_clr", req_ready, 0);

        // reset in the middle of a transaction (ptr is 2)
        req_start = 4'b0100;
        tick;
        chk("rb_start", m_start, 1);
        reset = 1'b1; req_start = '0;
        tick;
        chk("rb_m_start", m_start, 0);
        chk("rb_busy", busy, 0);
        chk("rb_grant", grant_id, 0);
        chk("rb_ready", req_ready, 0);
        chk("rb_rdata", req_rdata, 0);
        reset = 1'b0;
        req_start = 4'b1010;
        tick;
        chk("rb_fresh_grant", grant_id, 1);
        chk("rb_fresh_dev", m_dev_addr, 7'h11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
